// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings, state enum and helpers for the multi-cycle ARM-subset datapath.
package dp_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_LS  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_NOP = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    case (cond)
      COND_EQ: return nzcv[FLAG_Z];
      COND_NE: return !nzcv[FLAG_Z];
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_known(input logic [3:0] op);
    case (op)
      OP_AND, OP_SUB, OP_ADD, OP_CMP, OP_ORR, OP_MOV: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory req/ack buses of the multi-cycle datapath.
interface multicycle_datapath_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/multicycle_datapath_alu_nzcv.sv
// Combinational ALU: result plus next NZCV; logic ops pass C and V through.
module alu_nzcv
  import dp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      nzcv_in,
  output logic [XLEN-1:0] result,
  output logic [3:0]      nzcv_out
);
  logic [XLEN:0] sum;
  logic [XLEN:0] diff;
  logic          c;
  logic          v;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    c      = nzcv_in[FLAG_C];
    v      = nzcv_in[FLAG_V];
    case (op)
      OP_ADD: begin
        result = sum[XLEN-1:0];
        c      = sum[XLEN];
        v      = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB, OP_CMP: begin
        // diff[XLEN] is the borrow, so carry means a >= b unsigned
        result = diff[XLEN-1:0];
        c      = ~diff[XLEN];
        v      = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:  result = a & b;
      OP_ORR:  result = a | b;
      OP_MOV:  result = b;
      default: result = '0;
    endcase
    nzcv_out         = '0;
    nzcv_out[FLAG_N] = result[XLEN-1];
    nzcv_out[FLAG_Z] = (result == '0);
    nzcv_out[FLAG_C] = c;
    nzcv_out[FLAG_V] = v;
  end
endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle ARM-subset datapath: FETCH/DECODE/EXEC/MEM/WB over req/ack memories,
// with NZCV flags, conditional execution, branch-with-link and a retire pulse.
module multicycle_datapath
  import dp_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_datapath_if.master  mem,
  output logic [3:0]             flags,
  output logic                   retired,
  output logic [XLEN-1:0]        pc_out
);
  localparam int unsigned RW = $clog2(NREGS);

  state_e          state, state_nx;
  logic [XLEN-1:0] pc, a, b, res;
  logic [31:0]     ir;
  logic [3:0]      nzcv;
  logic [XLEN-1:0] regs [NREGS];

  logic [3:0]      cond, op;
  logic [1:0]      cls;
  logic            imm, sbit, link;
  logic [RW-1:0]   rn, rd, rm;
  logic            cond_ok, dp_writes, flag_upd;
  logic [XLEN-1:0] alu_res, br_target;
  logic [3:0]      alu_flags;

  assign cond      = ir[31:28];
  assign cls       = ir[27:26];
  assign imm       = ir[25];
  assign op        = ir[24:21];
  assign link      = ir[24];
  assign sbit      = ir[20];
  assign rn        = ir[16 +: RW];
  assign rd        = ir[12 +: RW];
  assign rm        = ir[0 +: RW];
  assign cond_ok   = cond_pass(cond, nzcv);
  assign dp_writes = (cls == CLS_DP) && op_known(op) && (op != OP_CMP);
  assign flag_upd  = (cls == CLS_DP) && op_known(op) && (sbit || (op == OP_CMP));
  // pc already points past this instruction, so it is the ARM "pc+4" base
  assign br_target = pc + {{(XLEN-26){ir[23]}}, ir[23:0], 2'b00};

  alu_nzcv #(.XLEN(XLEN)) u_alu (
    .op      (op),
    .a       (a),
    .b       (b),
    .nzcv_in (nzcv),
    .result  (alu_res),
    .nzcv_out(alu_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  if (mem.imem_ack) state_nx = DECODE;
      DECODE: state_nx = cond_ok ? EXEC : FETCH;
      EXEC: begin
        case (cls)
          CLS_BR:  state_nx = FETCH;
          CLS_LS:  state_nx = MEM;
          default: state_nx = WB;
        endcase
      end
      MEM:    if (mem.dmem_ack) state_nx = sbit ? WB : FETCH;
      WB:     state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Requests and retire are masked while reset is held so nothing leaks during reset.
  always_comb begin
    mem.imem_req   = reset && (state == FETCH);
    mem.imem_addr  = pc;
    mem.dmem_req   = reset && (state == MEM);
    mem.dmem_we    = reset && (state == MEM) && !sbit;
    mem.dmem_addr  = res;
    mem.dmem_wdata = b;
    retired        = 1'b0;
    case (state)
      DECODE:  retired = reset && !cond_ok;
      EXEC:    retired = reset && (cls == CLS_BR);
      MEM:     retired = reset && mem.dmem_ack && !sbit;
      WB:      retired = reset;
      default: retired = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc   <= RESET_PC;
      ir   <= '0;
      a    <= '0;
      b    <= '0;
      res  <= '0;
      nzcv <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem.imem_ack) begin
            ir <= mem.imem_rdata;
            pc <= pc + XLEN'(4);
          end
        end
        DECODE: begin
          a <= regs[rn];
          if (cls == CLS_DP) b <= imm ? XLEN'(ir[7:0]) : regs[rm];
          else               b <= regs[rd];
        end
        EXEC: begin
          case (cls)
            CLS_BR: begin
              pc <= br_target;
              if (link) regs[RW'(14)] <= pc;
            end
            CLS_LS: res <= a + XLEN'(ir[11:0]);
            default: begin
              res <= alu_res;
              if (flag_upd) nzcv <= alu_flags;
            end
          endcase
        end
        MEM: if (mem.dmem_ack && sbit) res <= mem.dmem_rdata;
        WB:  if ((cls == CLS_LS) || dp_writes) regs[rd] <= res;
        default: ;
      endcase
    end
  end

  assign flags  = nzcv;
  assign pc_out = pc;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with zero-wait imem and delay-programmable dmem.
module tb_multicycle_datapath;
  localparam logic [31:0] NEVER = 32'hF000_0000;
  localparam logic [3:0]  AL = 4'b1110, EQ = 4'b0000;
  localparam logic [3:0]  AND_ = 4'b0000, SUB_ = 4'b0010, ADD_ = 4'b0100;
  localparam logic [3:0]  CMP_ = 4'b1010, ORR_ = 4'b1100, MOV_ = 4'b1101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  flags;
  logic        retired;
  logic [31:0] pc_out;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          dcnt = 0;
  int          dmem_delay = 0;
  logic [31:0] imem  [64];
  logic [31:0] dinit [64];
  logic [31:0] dmem  [64];

  always #5 clk = ~clk;

  multicycle_datapath_if #(.XLEN(32)) bus ();

  multicycle_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (bus),
    .flags  (flags),
    .retired(retired),
    .pc_out (pc_out)
  );

  assign bus.imem_rdata = imem[bus.imem_addr[7:2]];
  assign bus.imem_ack   = bus.imem_req;
  assign bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];
  assign bus.dmem_ack   = bus.dmem_req && (dcnt >= dmem_delay);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.dmem_req && !bus.dmem_ack) dcnt <= dcnt + 1;
    else                               dcnt <= 0;
    if (!reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= dinit[i];
    end else if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
      dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
    end
  end

  function automatic logic [31:0] enc_dp(input logic [3:0] cond, input logic i, input logic [3:0] op,
                                         input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [7:0] op2);
    return {cond, 2'b00, i, op, s, rn, rd, 4'b0000, op2};
  endfunction

  function automatic logic [31:0] enc_ls(input logic [3:0] cond, input logic l, input logic [3:0] rn,
                                         input logic [3:0] rd, input logic [11:0] imm12);
    return {cond, 2'b01, 5'b00000, l, rn, rd, imm12};
  endfunction

  function automatic logic [31:0] enc_b(input logic [3:0] cond, input logic link, input logic [23:0] imm24);
    return {cond, 2'b10, 1'b0, link, imm24};
  endfunction

  task automatic clear_prog();
    reset = 1'b0;
    dmem_delay = 0;
    for (int i = 0; i < 64; i++) begin
      imem[i]  = NEVER;
      dinit[i] = 32'h0;
    end
  endtask

  task automatic start_prog(output int c0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 c0 = cyc;
  endtask

  task automatic wait_retire(output int t);
    int n = 0;
    t = -1;
    while (!retired && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (retired) t = cyc;
    else begin
      n_cmp++; n_fail++;
      $display("FAIL retire_timeout: no retire pulse within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic watch_dmem(input string name, input logic we, input logic [31:0] addr,
                            input logic chk_wd, input logic [31:0] wd, input int waits);
    int n = 0;
    logic stable = 1'b1;
    logic [31:0] a0, d0;
    logic w0;
    while (!bus.dmem_req && n < 100) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (bus.dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_req: dmem_req got %b expected 1", name, bus.dmem_req);
      return;
    end
    n_cmp++;
    if (bus.dmem_we !== we) begin n_fail++; $display("FAIL %s_we: got %b expected %b", name, bus.dmem_we, we); end
    n_cmp++;
    if (bus.dmem_addr !== addr) begin n_fail++; $display("FAIL %s_addr: got %h expected %h", name, bus.dmem_addr, addr); end
    if (chk_wd) begin
      n_cmp++;
      if (bus.dmem_wdata !== wd) begin n_fail++; $display("FAIL %s_wdata: got %h expected %h", name, bus.dmem_wdata, wd); end
    end
    a0 = bus.dmem_addr; d0 = bus.dmem_wdata; w0 = bus.dmem_we;
    n = 0;
    while (!bus.dmem_ack && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_addr !== a0 || bus.dmem_we !== w0 || bus.dmem_wdata !== d0) stable = 1'b0;
    end
    n_cmp++;
    if (stable !== 1'b1) begin n_fail++; $display("FAIL %s_stable: got %b expected 1", name, stable); end
    n_cmp++;
    if (n != waits) begin n_fail++; $display("FAIL %s_wait: got %0d expected %0d", name, n, waits); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_prog();
    imem[0] = enc_dp(AL, 1'b1, MOV_, 1'b0, 4'd0, 4'd1, 8'd5);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %b expected 0", bus.imem_req); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req: got %b expected 0", bus.dmem_req); end
    n_cmp++; if (bus.dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_we: got %b expected 0", bus.dmem_we); end
    n_cmp++; if (retired !== 1'b0) begin n_fail++; $display("FAIL rst_retired: got %b expected 0", retired); end
    n_cmp++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", flags); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", pc_out); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_fetch: got %b expected 1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_fetch_addr: got %h expected 0", bus.imem_addr); end
  endtask

  task automatic test_alu_sub();
    int c0, t1, t2, t3;
    clear_prog();
    imem[0] = enc_dp(AL, 1'b1, MOV_, 1'b0, 4'd0, 4'd1, 8'd5);
    imem[1] = enc_dp(AL, 1'b1, MOV_, 1'b0, 4'd0, 4'd2, 8'd3);
    imem[2] = enc_dp(AL, 1'b0, SUB_, 1'b1, 4'd1, 4'd3, 8'd2);
    start_prog(c0);
    wait_retire(t1); wait_retire(t2); wait_retire(t3);
    n_cmp++; if (t1 - c0 != 3) begin n_fail++; $display("FAIL mov_latency: got %0d expected 3", t1 - c0); end
    n_cmp++; if (t3 - t2 != 4) begin n_fail++; $display("FAIL sub_cycles: got %0d expected 4", t3 - t2); end
    n_cmp++; if (dut.regs[3] !== 32'd2) begin n_fail++; $display("FAIL sub_r3: got %h expected 2", dut.regs[3]); end
    n_cmp++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL sub_flags: got %b expected 0010", flags); end
  endtask

  task automatic test_cond_skip();
    int c0, t1, t2, t3, t4;
    clear_prog();
    imem[0] = enc_dp(AL, 1'b1, MOV_, 1'b0, 4'd0, 4'd1, 8'd5);
    imem[1] = enc_dp(AL, 1'b1, MOV_, 1'b0, 4'd0, 4'd2, 8'd3);
    imem[2] = enc_dp(AL, 1'b0, CMP_, 1'b0, 4'd2, 4'd0, 8'd1);
    imem[3] = enc_dp(EQ, 1'b1, ADD_, 1'b0, 4'd1, 4'd4, 8'd1);
    start_prog(c0);
    n_cmp++; if (dut.regs[3] !== 32'd0) begin n_fail++; $display("FAIL rst_regs_clear: got %h expected 0", dut.regs[3]); end
    wait_retire(t1); wait_retire(t2); wait_retire(t3);
    n_cmp++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL cmp_flags: got %b expected 1000", flags); end
    wait_retire(t4);
    n_cmp++; if (t4 - t3 != 2) begin n_fail++; $display("FAIL skip_cycles: got %0d expected 2", t4 - t3); end
    n_cmp++; if (dut.regs[4] !== 32'd0) begin n_fail++; $display("FAIL skip_r4: got %h expected 0", dut.regs[4]); end
    n_cmp++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL skip_flags: got %b expected 1000", flags); end
  endtask

  task automatic test_load_store();
    int c0, t;
    clear_prog();
    imem[0] = enc_dp(AL, 1'b1, MOV_, 1'b0, 4'd0, 4'd1, 8'h80);
    imem[1] = enc_dp(AL, 1'b0, ADD_, 1'b0, 4'd1, 4'd1, 8'd1);
    imem[2] = enc_ls(AL, 1'b0, 4'd1, 4'd1, 12'h004);
    imem[3] = enc_ls(AL, 1'b1, 4'd1, 4'd5, 12'h004);
    dmem_delay = 3;
    start_prog(c0);
    wait_retire(t); wait_retire(t);
    n_cmp++; if (dut.regs[1] !== 32'h100) begin n_fail++; $display("FAIL ls_r1: got %h expected 100", dut.regs[1]); end
    watch_dmem("store", 1'b1, 32'h104, 1'b1, 32'h100, 3);
    n_cmp++; if (dmem[1] !== 32'h100) begin n_fail++; $display("FAIL store_mem: got %h expected 100", dmem[1]); end
    watch_dmem("load", 1'b0, 32'h104, 1'b0, 32'h0, 3);
    wait_retire(t);
    n_cmp++; if (dut.regs[5] !== 32'h100) begin n_fail++; $display("FAIL load_r5: got %h expected 100", dut.regs[5]); end
  endtask

  task automatic test_branch_link();
    int c0, t, tp;
    clear_prog();
    imem[8] = enc_b(AL, 1'b1, 24'hFFFFFE);
    start_prog(c0);
    tp = 0;
    for (int k = 0; k < 8; k++) wait_retire(tp);
    wait_retire(t);
    n_cmp++; if (t - tp != 3) begin n_fail++; $display("FAIL branch_cycles: got %0d expected 3", t - tp); end
    n_cmp++; if (dut.regs[14] !== 32'h24) begin n_fail++; $display("FAIL bl_r14: got %h expected 24", dut.regs[14]); end
    n_cmp++; if (bus.imem_addr !== 32'h1C) begin n_fail++; $display("FAIL bl_target: got %h expected 1c", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL bl_refetch: got %b expected 1", bus.imem_req); end
  endtask

  task automatic test_add_flags();
    int c0, t;
    clear_prog();
    dinit[16] = 32'h7FFF_FFFF;
    dinit[17] = 32'hFFFF_FFFF;
    imem[0] = enc_ls(AL, 1'b1, 4'd0, 4'd1, 12'h040);
    imem[1] = enc_dp(AL, 1'b1, ADD_, 1'b1, 4'd1, 4'd2, 8'd1);
    imem[2] = enc_ls(AL, 1'b1, 4'd0, 4'd3, 12'h044);
    imem[3] = enc_dp(AL, 1'b1, ADD_, 1'b1, 4'd3, 4'd4, 8'd1);
    imem[4] = enc_dp(AL, 1'b1, ORR_, 1'b1, 4'd1, 4'd5, 8'h80);
    start_prog(c0);
    wait_retire(t); wait_retire(t);
    n_cmp++; if (dut.regs[2] !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result: got %h expected 80000000", dut.regs[2]); end
    n_cmp++; if (flags !== 4'b1001) begin n_fail++; $display("FAIL ovf_flags: got %b expected 1001", flags); end
    wait_retire(t); wait_retire(t);
    n_cmp++; if (dut.regs[4] !== 32'h0) begin n_fail++; $display("FAIL carry_result: got %h expected 0", dut.regs[4]); end
    n_cmp++; if (flags !== 4'b0110) begin n_fail++; $display("FAIL carry_flags: got %b expected 0110", flags); end
    wait_retire(t);
    n_cmp++; if (dut.regs[5] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL orr_result: got %h expected 7fffffff", dut.regs[5]); end
    n_cmp++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL orr_flags: got %b expected 0010", flags); end
  endtask

  task automatic test_reset_in_mem();
    int c0, c1, t, n;
    clear_prog();
    imem[0] = enc_dp(AL, 1'b1, CMP_, 1'b0, 4'd0, 4'd0, 8'd1);
    imem[1] = enc_ls(AL, 1'b0, 4'd0, 4'd0, 12'h010);
    dmem_delay = 20;
    start_prog(c0);
    wait_retire(t);
    n = 0;
    while (!bus.dmem_req && n < 50) begin @(posedge clk); #1; n++; end
    n_cmp++; if (bus.dmem_req !== 1'b1) begin n_fail++; $display("FAIL mrst_in_mem: got %b expected 1", bus.dmem_req); end
    n_cmp++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL mrst_pre_flags: got %b expected 1000", flags); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL mrst_dmem_req: got %b expected 0", bus.dmem_req); end
    n_cmp++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL mrst_flags: got %b expected 0000", flags); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL mrst_pc: got %h expected 0", pc_out); end
    reset = 1'b1;
    #1 c1 = cyc;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL mrst_imem_req: got %b expected 1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL mrst_imem_addr: got %h expected 0", bus.imem_addr); end
    n_cmp++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL mrst_dmem_idle: got %b expected 0", bus.dmem_req); end
    wait_retire(t);
    n_cmp++; if (t - c1 != 3) begin n_fail++; $display("FAIL mrst_restart: got %0d expected 3", t - c1); end
  endtask

  initial begin
    test_reset();
    test_alu_sub();
    test_cond_skip();
    test_load_store();
    test_branch_link();
    test_add_flags();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle ARM-subset datapath.
- Executes one instruction over several cycles through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Talks to external instruction and data memories over req/ack handshakes.
- Adds behaviour the single-cycle datapath lacks: an NZCV status register, conditional execution, S-bit flag updates, branch-with-link and a retire pulse.

Parameters:
- XLEN, 32: data/address width; must be ≥ 32.
- NREGS, 16: register count; register index width is log2(NREGS), max 16 (4-bit fields).
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  XLEN  data address
- dmem_wdata  out  XLEN  store data
- dmem_rdata  in  XLEN  load data, valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- flags  out  4  {N,Z,C,V}
- retired  out  1  one-cycle pulse per completed or skipped instruction
- pc_out  out  XLEN  current pc

Behaviour:

Reset (reset=0 sampled at a clk edge):
- pc=RESET_PC, state=FETCH, flags=0000, all registers=0.
- imem_req, dmem_req, dmem_we and retired are 0 on the next cycle.
- Reset overrides any in-flight handshake; a late ack after reset is ignored.

Encoding:
- [31:28] cond: 0000 EQ (Z=1), 0001 NE (Z=0), 1110 AL; any other value is treated as never.
- [27:26] class: 00 data-processing, 01 load/store, 10 branch, 11 treated as NOP.
- Data-processing:
  - [25] I, [24:21] op, [20] S, [19:16] Rn, [15:12] Rd.
  - Operand2 = zero-extended imm8 [7:0] if I=1, else Rm [3:0].
  - ops: AND 0000, SUB 0010, ADD 0100, CMP 1010, ORR 1100, MOV 1101; other ops are NOP.
- Load/store:
  - [20] L (1 = load), Rn is the base, Rd is data, address = Rn + zero-extended imm12 [11:0].
- Branch:
  - [24] link.
  - target = (pc+4) + (sign-extended imm24 << 2).
  - If link=1, R14 is written with pc+4.
- All registers, including R15, are general purpose.

FSM:
- FETCH:
  - imem_req=1 with imem_addr=pc, held stable until imem_ack.
  - On ack: latch IR, pc <= pc+4, go to DECODE. Ack in the first req cycle is legal, so minimum FETCH is 1 cycle.
- DECODE:
  - Read Rn and Rm/Rd into A and B; evaluate cond.
  - If cond fails: pulse retired and go to FETCH.
- EXEC:
  - Compute the ALU result, or the address, or the branch target.
  - Branch: update pc, write the link register if required, pulse retired, go to FETCH.
  - Data-processing: go to WB.
  - Load/store: go to MEM.
- MEM:
  - dmem_req=1 with addr, we and wdata held stable until dmem_ack.
  - On ack: a store pulses retired and goes to FETCH; a load latches rdata and goes to WB.
- WB:
  - Write Rd (CMP and NOP do not write), pulse retired, go to FETCH.

Cycle counts with zero-wait memory:
- ALU op: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.
- Skipped instruction: 2 cycles.

ALU and flags (XLEN-bit, wrap-around arithmetic):
- Flags update in EXEC only when S=1 or the op is CMP.
- ADD: C = carry-out, V = signed overflow.
- SUB/CMP: result = A-B; C = 1 when there is no borrow (A ≥ B unsigned); V = signed overflow.
- AND/ORR/MOV: N and Z update; C and V are unchanged.

Decomposition:
- Package dp_pkg holds:
  - cond, class and opcode constants;
  - the state enum {FETCH, DECODE, EXEC, MEM, WB};
  - the flag bit indices.
- One sub-module: alu_nzcv (combinational ALU producing the result and next NZCV).
- Register file and FSM stay in the top level.

Test Plan:
- Sequence MOV R1,#5 (I=1); MOV R2,#3; SUB S R3,R1,R2 with zero-wait memory → R3=2; flags N=0, Z=0, C=1, V=0; retired pulses 3 times; SUB takes 4 cycles.
- CMP R2,R1 (3−5), then ADD EQ R4,R1,#1 → flags N=1, C=0; ADD is skipped, R4 stays 0; retired pulses 2 cycles after its fetch.
- R1=0x100. STR R1,[R1,#4] then LDR R5,[R1,#4], with dmem_ack delayed 3 cycles → dmem_addr=0x104 with dmem_we=1, then 0; req/addr/wdata held stable while waiting; R5=0x100.
- At pc=0x20, branch-with-link with imm24=0xFFFFFE (−2) → R14=0x24; next imem_addr=0x1C.
- ADD S of 0x7FFFFFFF + 1 (XLEN=32) → result 0x80000000; N=1, V=1, C=0, Z=0.
- Reset=0 asserted during MEM with dmem_req=1 → next cycle dmem_req=0, imem_req=1 at RESET_PC, flags=0000.
